logic_exec_pipe: RTL

//  Parametrised, two-stage pipelined logical execution unit for the integer execute cluster.

---
 rtl/logic_exec_pipe_pkg.sv | 16 +
 rtl/logic_exec_pipe_fn_core.sv | 41 ++++
 rtl/logic_exec_pipe.sv | 93 +++++++++
 3 files changed

// File: rtl/logic_exec_pipe_pkg.sv
// Shared function codes and field positions for the logical execution pipe.
// Shift codes are only legal when LOGIC_SHIFT_EN is defined.
package logic_exec_pipe_pkg;

   typedef enum logic [2:0] {
      LOGIC_FN_AND = 3'b000,
      LOGIC_FN_OR  = 3'b001,
      LOGIC_FN_XOR = 3'b010,
      LOGIC_FN_SLL = 3'b011,
      LOGIC_FN_SRL = 3'b100,
      LOGIC_FN_SRA = 3'b101
   } logic_fn_e;

   localparam int LOGIC_IMM_SEL = 3;

endpackage

// File: rtl/logic_exec_pipe_fn_core.sv
// Combinational logic/shift core (logic_fn_core); unsupported codes give result 0 and illegal=1.
// The shifter exists only when LOGIC_SHIFT_EN is defined.
module logic_fn_core
   import logic_exec_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  illegal
);

   logic_fn_e fn;
   assign fn = logic_fn_e'(op);

`ifdef LOGIC_SHIFT_EN
   localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
   logic [SHAMT_WIDTH-1:0] shamt;
   assign shamt = b[SHAMT_WIDTH-1:0];
`endif

   always_comb begin
      // NOTE: every output gets a default first so no path through the case can infer a latch.
      result  = '0;
      illegal = 1'b0;
      case (fn)
         LOGIC_FN_AND: result = a & b;
         LOGIC_FN_OR:  result = a | b;
         LOGIC_FN_XOR: result = a ^ b;
`ifdef LOGIC_SHIFT_EN
         LOGIC_FN_SLL: result = a << shamt;
         LOGIC_FN_SRL: result = a >> shamt;
         LOGIC_FN_SRA: result = $unsigned($signed(a) >>> shamt);
`endif
         default:      illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/logic_exec_pipe.sv
// Two-stage pipelined logical execution unit with valid/ready handshake, tag pass-through and flush.
// Define LOGIC_SHIFT_EN to enable the SLL/SRL/SRA function codes.
module logic_exec_pipe
   import logic_exec_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 12,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            op_type,
   input  logic [DATA_WIDTH-1:0] src1,
   input  logic [DATA_WIDTH-1:0] src2,
   input  logic [IMM_WIDTH-1:0]  immediate,
   input  logic [TAG_WIDTH-1:0]  tag_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic [TAG_WIDTH-1:0]  tag_out,
   output logic                  illegal_op
);

   logic                  s1_valid;
   logic [2:0]            s1_op;
   logic [DATA_WIDTH-1:0] s1_a;
   logic [DATA_WIDTH-1:0] s1_b;
   logic [TAG_WIDTH-1:0]  s1_tag;
   logic                  s2_valid;

   logic                  s1_adv;
   logic                  s2_adv;
   logic                  accept;
   logic [DATA_WIDTH-1:0] src2_eff;
   logic [DATA_WIDTH-1:0] fn_result;
   logic                  fn_illegal;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_valid;

   assign src2_eff = op_type[LOGIC_IMM_SEL] ? DATA_WIDTH'($signed(immediate)) : src2;

   // NOTE: stage-1 operands carry no reset; s1_valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_op  <= op_type[2:0];
         s1_a   <= src1;
         s1_b   <= src2_eff;
         s1_tag <= tag_in;
      end
   end

   logic_fn_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fn_core (
      .op      (s1_op),
      .a       (s1_a),
      .b       (s1_b),
      .result  (fn_result),
      .illegal (fn_illegal)
   );

   // NOTE: state uses non-blocking assignments so both stages update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         result     <= '0;
         tag_out    <= '0;
         illegal_op <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               result     <= fn_result;
               tag_out    <= s1_tag;
               illegal_op <= fn_illegal;
            end
         end
      end
   end

endmodule
